// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-copy DMA initiator on the 68-bit put/get memory port
module mem_copy_engine #(
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_src,
  input  logic [31:0]          cmd_dst,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 put_valid,
  input  logic                 put_ready,
  output logic [67:0]          put_request,
  output logic                 get_valid,
  input  logic                 get_ready,
  input  logic [67:0]          get_response,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_WIDTH-1:0] words_done
);

  localparam int                   WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]    WAIT_ONE  = WAIT_W'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;

  state_t               state, state_d;
  logic [31:0]          src_addr, src_addr_d;
  logic [31:0]          dst_addr, dst_addr_d;
  logic [31:0]          hold, hold_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, words_d;
  logic [WAIT_W-1:0]    wait_cnt, wait_d;
  logic                 err_d;
  logic                 put_valid_d;
  logic [67:0]          put_request_d;
  logic [3:0]           resp_be;
  logic [31:0]          resp_addr;
  logic [31:0]          resp_data;
  logic                 wait_expired;

  assign resp_be      = get_response[67:64];
  assign resp_addr    = get_response[63:32];
  assign resp_data    = get_response[31:0];
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Status and response-side handshake decode straight from the state register
  assign cmd_ready = (state == IDLE);
  assign get_valid = state inside {IDLE, RD_WAIT, WR_WAIT, FIN};
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // Next-state, datapath and next request; src_addr/dst_addr always hold the address of word i
  always_comb begin
    state_d    = state;
    src_addr_d = src_addr;
    dst_addr_d = dst_addr;
    hold_d     = hold;
    len_d      = len_q;
    words_d    = words_done;
    wait_d     = wait_cnt;
    err_d      = err;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          src_addr_d = cmd_src;
          dst_addr_d = cmd_dst;
          len_d      = cmd_len;
          words_d    = '0;
          err_d      = 1'b0;
          state_d    = (cmd_len == '0) ? FIN : RD_REQ;
        end
      end
      RD_REQ: begin
        if (put_ready) begin
          wait_d  = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (get_ready) begin
          if (resp_be == 4'h0 && resp_addr == src_addr) begin
            hold_d  = resp_data;
            state_d = WR_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wait_d = wait_cnt + WAIT_ONE;
        end
      end
      WR_REQ: begin
        if (put_ready) begin
          wait_d  = '0;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (get_ready) begin
          if (resp_be == 4'hF && resp_addr == dst_addr) begin
            words_d    = words_done + LEN_ONE;
            src_addr_d = src_addr + 32'd4;
            dst_addr_d = dst_addr + 32'd4;
            state_d    = (words_d == len_q) ? FIN : RD_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wait_d = wait_cnt + WAIT_ONE;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    put_valid_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    put_request_d = put_request;
    if (state_d == RD_REQ) begin
      put_request_d = {4'h0, src_addr_d, 32'h0};
    end else if (state_d == WR_REQ) begin
      put_request_d = {4'hF, dst_addr_d, hold_d};
    end
  end

  // State, datapath and registered request outputs; reset aborts any command in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      src_addr    <= '0;
      dst_addr    <= '0;
      hold        <= '0;
      len_q       <= '0;
      words_done  <= '0;
      wait_cnt    <= '0;
      err         <= 1'b0;
      put_valid   <= 1'b0;
      put_request <= '0;
    end else begin
      state       <= state_d;
      src_addr    <= src_addr_d;
      dst_addr    <= dst_addr_d;
      hold        <= hold_d;
      len_q       <= len_d;
      words_done  <= words_d;
      wait_cnt    <= wait_d;
      err         <= err_d;
      put_valid   <= put_valid_d;
      put_request <= put_request_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine with a behavioural memory
module tb_mem_copy_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic        put_valid;
  logic        put_ready = 1'b0;
  logic [67:0] put_request;
  logic        get_valid;
  logic        get_ready = 1'b0;
  logic [67:0] get_response = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_done;

  mem_copy_engine #(.LEN_WIDTH(16), .TIMEOUT(1024)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .put_valid(put_valid), .put_ready(put_ready), .put_request(put_request),
    .get_valid(get_valid), .get_ready(get_ready), .get_response(get_response),
    .busy(busy), .done(done), .err(err), .words_done(words_done)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural memory state and knobs
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [67:0] rq[$];
  logic [31:0] rd_log[$];
  int          put_stall = 0;
  int          get_delay = 0;
  int          corrupt_n = 0;
  int          reads_in_cmd = 0;
  int          writes_total = 0;
  int          puts_total = 0;
  int          unstable = 0;
  bit          hold_get = 1'b0;
  bit          p_fire = 1'b0;
  bit          g_fire = 1'b0;
  logic [67:0] fire_req = '0;
  int          stall_cnt = 0;
  int          delay_cnt = 0;
  bit          req_seen = 1'b0;
  logic [67:0] req_snap = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  // Record the handshakes that the coming edge completes (pre-edge values)
  always @(posedge CLK) begin
    p_fire   = put_valid && put_ready && !RST;
    g_fire   = get_valid && get_ready && !RST;
    fire_req = put_request;
  end

  // Memory: execute accepted requests, answer one cycle later, apply stalls and faults
  always @(negedge CLK) begin
    logic [67:0] resp;
    if (g_fire && rq.size() > 0) void'(rq.pop_front());
    if (p_fire) begin
      puts_total++;
      req_seen  = 1'b0;
      stall_cnt = 0;
      resp      = fire_req;
      if (fire_req[67:64] == 4'h0) begin
        reads_in_cmd++;
        rd_log.push_back(fire_req[63:32]);
        resp[31:0] = mem_rd(fire_req[63:32]);
        if (reads_in_cmd == corrupt_n) resp[63:32] = resp[63:32] ^ 32'h4;
      end else begin
        writes_total++;
        mem[fire_req[63:32]] = fire_req[31:0];
      end
      rq.push_back(resp);
      delay_cnt = get_delay;
    end
    if (put_valid) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        req_snap = put_request;
      end else if (put_request !== req_snap) begin
        unstable++;
      end
      if (stall_cnt < put_stall) begin
        put_ready = 1'b0;
        stall_cnt++;
      end else begin
        put_ready = 1'b1;
      end
    end else begin
      put_ready = 1'b0;
    end
    if (rq.size() > 0 && !hold_get) begin
      if (delay_cnt > 0) begin
        get_ready = 1'b0;
        delay_cnt--;
      end else begin
        get_ready = 1'b1;
      end
    end else begin
      get_ready = 1'b0;
    end
    get_response = (rq.size() > 0) ? rq[0] : '0;
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                         input int budget, output int cyc);
    @(negedge CLK);
    check("cmd_ready", 68'(cmd_ready), 68'(1));
    reads_in_cmd = 0;
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = l;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("err_cleared", 68'(err), 68'(0));
    cyc = 1;
    while (!done && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    check("done_seen", 68'(done), 68'(1));
  endtask

  task automatic copy_and_check(input string tag, input logic [31:0] s, input logic [31:0] d,
                                input int n, input int stall, input int gdel, input bit timed);
    int          cyc;
    logic [31:0] a;
    ref_mem = mem;
    for (int i = 0; i < n; i++) ref_mem[d + 32'(4 * i)] = ref_rd(s + 32'(4 * i));
    put_stall = stall;
    get_delay = gdel;
    unstable  = 0;
    run_cmd(s, d, 16'(n), 400, cyc);
    if (timed) check({tag, "_latency"}, 68'(cyc), 68'(4 * n + 1));
    check({tag, "_busy_fin"}, 68'(busy), 68'(1));
    check({tag, "_words"}, 68'(words_done), 68'(n));
    check({tag, "_err"}, 68'(err), 68'(0));
    check({tag, "_stable"}, 68'(unstable), 68'(0));
    for (int i = 0; i < n; i++) begin
      a = d + 32'(4 * i);
      check({tag, "_dst"}, 68'(mem_rd(a)), 68'(ref_rd(a)));
      a = s + 32'(4 * i);
      check({tag, "_src"}, 68'(mem_rd(a)), 68'(ref_rd(a)));
    end
    put_stall = 0;
    get_delay = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          p0;
    int          w0;
    int          n;
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] la;

    // Reset values
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", 68'(cmd_ready), 68'(1));
    check("rst_put_valid", 68'(put_valid), 68'(0));
    check("rst_put_request", put_request, 68'(0));
    check("rst_get_valid", 68'(get_valid), 68'(1));
    check("rst_busy", 68'(busy), 68'(0));
    check("rst_done", 68'(done), 68'(0));
    check("rst_err", 68'(err), 68'(0));
    check("rst_words", 68'(words_done), 68'(0));
    RST = 1'b0;

    // Basic copy of four words with a zero-latency memory
    mem[32'h100] = 32'hAAAA_0001;
    mem[32'h104] = 32'hBBBB_0002;
    mem[32'h108] = 32'hCCCC_0003;
    mem[32'h10C] = 32'hDDDD_0004;
    copy_and_check("basic", 32'h100, 32'h200, 4, 0, 0, 1'b1);
    check("basic_word3", 68'(mem_rd(32'h20C)), 68'(32'hDDDD_0004));

    // Zero length: no requests, done almost immediately
    p0 = puts_total;
    run_cmd(32'h100, 32'h300, 16'd0, 10, cyc);
    check("zero_done_window", 68'(cyc >= 1 && cyc <= 2), 68'(1));
    check("zero_no_puts", 68'(puts_total), 68'(p0));
    check("zero_words", 68'(words_done), 68'(0));

    // Backpressure: five stalled cycles at every request
    copy_and_check("bp", 32'h100, 32'h280, 3, 5, 0, 1'b0);

    // Address wrap at the top of the 32-bit space
    rd_log.delete();
    copy_and_check("wrap", 32'hFFFF_FFF8, 32'h600, 4, 0, 0, 1'b1);
    check("wrap_reads", 68'(rd_log.size()), 68'(4));
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      la = 32'hFFFF_FFF8 + 32'(4 * i);
      check("wrap_addr", 68'(rd_log[i]), 68'(la));
    end

    // Corrupted address on the second read response
    corrupt_n = 2;
    w0 = writes_total;
    run_cmd(32'h700, 32'h800, 16'd4, 100, cyc);
    check("mm_err", 68'(err), 68'(1));
    check("mm_words", 68'(words_done), 68'(1));
    check("mm_writes", 68'(writes_total - w0), 68'(1));
    corrupt_n = 0;
    copy_and_check("after_mm", 32'h700, 32'h900, 2, 0, 0, 1'b1);

    // Timeout with the response withheld, then the stale response drained in IDLE
    hold_get = 1'b1;
    run_cmd(32'h400, 32'h500, 16'd2, 1200, cyc);
    check("to_err", 68'(err), 68'(1));
    check("to_window", 68'(cyc >= 1024 && cyc <= 1030), 68'(1));
    check("to_words", 68'(words_done), 68'(0));
    @(negedge CLK);
    hold_get = 1'b0;
    repeat (3) @(negedge CLK);
    check("to_drained", 68'(rq.size()), 68'(0));

    // Reset while waiting on a read, then drain and run a fresh command
    hold_get = 1'b1;
    @(negedge CLK);
    reads_in_cmd = 0;
    cmd_valid = 1'b1;
    cmd_src   = 32'hA00;
    cmd_dst   = 32'hB00;
    cmd_len   = 16'd3;
    @(negedge CLK);
    cmd_valid = 1'b0;
    n = 0;
    while (rq.size() == 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("rs_pending", 68'(rq.size() > 0), 68'(1));
    check("rs_busy", 68'(busy), 68'(1));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rs_idle", 68'(busy), 68'(0));
    check("rs_put_valid", 68'(put_valid), 68'(0));
    p0 = puts_total;
    hold_get = 1'b0;
    repeat (3) @(negedge CLK);
    check("rs_drained", 68'(rq.size()), 68'(0));
    check("rs_no_puts", 68'(puts_total), 68'(p0));
    copy_and_check("rs_new", 32'hA00, 32'hC00, 3, 0, 0, 1'b1);

    // Randomized copies, some with overlapping regions and slow memory
    for (int k = 0; k < 8; k++) begin
      s = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 1) == 1) d = s + 32'(4 * ($urandom_range(0, 4) - 2));
      else d = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = $urandom;
      copy_and_check("rand", s, d, n, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
